// File: rtl/note_lane.sv
// note_lane: one falling-note lane with block motion, hit/miss scoring and pixel colouring.
// Define NOTE_LANE_RANDOM_SPAWN_EN to add an LFSR-randomised WAIT before each respawn.
module note_lane #(
    parameter logic [9:0]  LANE_X0     = 10'd200,
    parameter logic [9:0]  LANE_W      = 10'd80,
    parameter logic [9:0]  BLOCK_H     = 10'd40,
    parameter logic [9:0]  SPAWN_Y     = 10'd35,
    parameter logic [9:0]  ZONE_TOP    = 10'd400,
    parameter logic [9:0]  ZONE_BOT    = 10'd455,
    parameter logic [9:0]  BOTTOM_Y    = 10'd515,
    parameter logic [49:0] BASE_PERIOD = 50'd250000,
    parameter logic [49:0] MIN_PERIOD  = 50'd50000,
    parameter logic [3:0]  MAX_MISS    = 4'd3,
    parameter logic [3:0]  HIT_HOLD    = 4'd8
) (
    input  logic        clk,
    input  logic        resetbtn,
    input  logic [1:0]  gamestate,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        btn,
    input  logic [49:0] speedshift,
    output logic [1:0]  colorflag,
    output logic        pointflag,
    output logic        blockgoneflag,
    output logic [3:0]  missCount
);
    localparam logic [1:0] TITLESCREEN = 2'b01;
    localparam logic [1:0] STARTGAME   = 2'b10;

    typedef enum logic [2:0] {
        IDLE, FALL, HIT, GONE
`ifdef NOTE_LANE_RANDOM_SPAWN_EN
        , WAIT
`endif
    } state_t;

    state_t      state, state_n, spawn_state;
    logic [9:0]  block_y, block_y_n, step_y, bot_y, end_y;
    logic [49:0] div, div_n, period;
    logic [3:0]  miss, miss_n, cnt, cnt_n, spawn_cnt;
    logic        point_n, tick, overlap, in_x, in_y;

    assign period  = (speedshift >= BASE_PERIOD - MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD - speedshift;
    assign tick    = div >= period - 50'd1;
    assign step_y  = block_y + 10'd1;
    assign bot_y   = block_y + BLOCK_H - 10'd1;
    assign end_y   = block_y + BLOCK_H;
    assign overlap = (bot_y >= ZONE_TOP) && (block_y <= ZONE_BOT);
    assign missCount = miss;

`ifdef NOTE_LANE_RANDOM_SPAWN_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or posedge resetbtn)
        if (resetbtn)
            lfsr <= 8'hA5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign spawn_state = WAIT;
    assign spawn_cnt   = lfsr[3:0];
`else
    assign spawn_state = FALL;
    assign spawn_cnt   = 4'd0;
`endif

    always_ff @(posedge clk or posedge resetbtn)
        if (resetbtn) begin
            state     <= IDLE;
            block_y   <= SPAWN_Y;
            div       <= '0;
            miss      <= '0;
            cnt       <= '0;
            pointflag <= 1'b0;
        end else begin
            state     <= state_n;
            block_y   <= block_y_n;
            div       <= div_n;
            miss      <= miss_n;
            cnt       <= cnt_n;
            pointflag <= point_n;
        end

    always_comb begin
        state_n   = state;
        block_y_n = block_y;
        div_n     = div;
        miss_n    = miss;
        cnt_n     = cnt;
        point_n   = 1'b0;
        if (gamestate == TITLESCREEN) begin
            state_n   = IDLE;
            block_y_n = SPAWN_Y;
            div_n     = '0;
            miss_n    = '0;
        end else if (gamestate == STARTGAME && state == IDLE) begin
            state_n   = FALL;
            block_y_n = SPAWN_Y;
            div_n     = '0;
        end else if (gamestate == STARTGAME && state != GONE) begin
            div_n = tick ? '0 : div + 50'd1;
            // a hit outranks a coincident tick, so the frozen row is the one the player saw
            if (state == FALL && btn && overlap) begin
                state_n = HIT;
                cnt_n   = HIT_HOLD - 4'd1;
                point_n = 1'b1;
            end else if (tick && state == FALL && step_y > BOTTOM_Y) begin
                miss_n    = miss + 4'd1;
                block_y_n = SPAWN_Y;
                state_n   = (miss + 4'd1 == MAX_MISS) ? GONE : spawn_state;
                cnt_n     = spawn_cnt;
            end else if (tick && state == FALL) begin
                block_y_n = step_y;
            end else if (tick && state == HIT) begin
                block_y_n = (cnt == 4'd0) ? SPAWN_Y : block_y;
                state_n   = (cnt == 4'd0) ? spawn_state : HIT;
                cnt_n     = (cnt == 4'd0) ? spawn_cnt : cnt - 4'd1;
            end
`ifdef NOTE_LANE_RANDOM_SPAWN_EN
            else if (tick && state == WAIT) begin
                state_n = (cnt == 4'd0) ? FALL : WAIT;
                cnt_n   = cnt - 4'd1;
            end
`endif
        end
    end

    always_comb begin
        in_x          = (hCount >= LANE_X0) && (hCount < LANE_X0 + LANE_W);
        in_y          = (vCount >= block_y) && (vCount < end_y);
        colorflag     = !(in_x && in_y) ? 2'b00 : state == FALL ? 2'b01 : state == HIT ? 2'b10 : 2'b00;
        blockgoneflag = state == GONE;
    end
endmodule

// File: doc/note_lane.md
NOTE_LANE -- requirements
Module: note_lane

Interface
REQ-001 Parameter LANE_X0, 10'd200, left column of the lane (hCount units).
REQ-002 Parameter LANE_W, 10'd80, lane/block width in pixels.
REQ-003 Parameter BLOCK_H, 10'd40, block height in pixels.
REQ-004 Parameter SPAWN_Y, 10'd35, top row of a freshly spawned block.
REQ-005 Parameter ZONE_TOP / ZONE_BOT, 10'd400 / 10'd455, hit-zone rows, inclusive.
REQ-006 Parameter BOTTOM_Y, 10'd515, last visible row.
REQ-007 Parameter BASE_PERIOD / MIN_PERIOD, 50'd250000 / 50'd50000, clocks per 1-pixel step before/after speed-up.
REQ-008 Parameter MAX_MISS, 4'd3, misses before the lane is gone; HIT_HOLD, 4'd8, steps the green hit block stays visible.
REQ-009 clk  in  1  system clock; all state on rising edge.
REQ-010 resetbtn  in  1  asynchronous, active-high reset.
REQ-011 gamestate  in  2  01 TITLESCREEN, 10 STARTGAME, 11 GAMEOVER.
REQ-012 hCount, vCount  in  10 each  current VGA pixel.
REQ-013 btn  in  1  debounced single-cycle press pulse for this lane.
REQ-014 speedshift  in  50  period reduction from the score logic.
REQ-015 colorflag  out  2  00 none, 01 falling block at pixel, 10 hit (green) block at pixel.
REQ-016 pointflag  out  1  one-cycle pulse per successful hit.
REQ-017 blockgoneflag  out  1  lane exhausted, sticky.
REQ-018 missCount  out  4  misses so far this game.

Function
REQ-019 States IDLE, FALL, HIT, GONE (plus WAIT when REQ-034 is enabled); IDLE while gamestate != STARTGAME.
REQ-020 IDLE -> FALL on gamestate == STARTGAME, blockY = SPAWN_Y, divider = 0.
REQ-021 Step period = BASE_PERIOD - speedshift, saturated at MIN_PERIOD when speedshift >= BASE_PERIOD - MIN_PERIOD; period sampled at each tick.
REQ-022 Divider counts 0..period-1 and pulses tick at period-1, then wraps to 0; in FALL each tick adds 1 to blockY.
REQ-023 Overlap = (blockY + BLOCK_H - 1 >= ZONE_TOP) && (blockY <= ZONE_BOT), 10-bit unsigned compare.
REQ-024 btn in FALL with overlap: pointflag = 1 on the next cycle for exactly one cycle; state -> HIT; blockY frozen; a same-cycle tick is discarded.
REQ-025 btn in FALL without overlap, or btn in any other state, is ignored.
REQ-026 HIT lasts HIT_HOLD ticks, then respawns (blockY = SPAWN_Y, FALL).
REQ-027 Miss: FALL with blockY > BOTTOM_Y after a tick; missCount += 1; respawn, or GONE when the new missCount == MAX_MISS.
REQ-028 GONE: blockgoneflag = 1, colorflag = 00, no ticks, no points, until reset or gamestate == TITLESCREEN.
REQ-029 gamestate == GAMEOVER: freeze blockY, divider, missCount; pointflag held 0; colorflag still drawn.
REQ-030 gamestate == TITLESCREEN from any state: -> IDLE, missCount = 0, blockgoneflag = 0.
REQ-031 colorflag is combinational from registered state, with zero pixel latency: nonzero only when LANE_X0 <= hCount < LANE_X0 + LANE_W and blockY <= vCount < blockY + BLOCK_H; 01 in FALL, 10 in HIT.

Reset
REQ-032 On resetbtn: state IDLE, blockY = SPAWN_Y, divider = 0, missCount = 0, pointflag = 0, blockgoneflag = 0; colorflag therefore 00.
REQ-033 Reset mid-FALL or mid-HIT aborts the block with no point and no miss recorded.

Configuration
REQ-034 NOTE_LANE_RANDOM_SPAWN_EN defined: an 8-bit LFSR (taps 8,6,5,4; reset seed 8'hA5; advances every clock) is added; each respawn enters WAIT for LFSR[3:0] + 1 ticks with colorflag = 00, then FALL; undefined: respawn enters FALL directly, and the LFSR and WAIT are absent.

Verification
REQ-035 Reset, gamestate = 10, speedshift = 0 -> blockY steps 35 -> 36 after exactly 250000 clocks; colorflag = 01 at (hCount 200, vCount 35), 00 at (hCount 280, vCount 35).
REQ-036 Block at blockY = 380 (rows 380..419), btn pulse -> one-cycle pointflag, colorflag = 10 for 8 ticks, then respawn at 35.
REQ-037 btn pulse at blockY = 300 -> no pointflag; block reaches 516 -> missCount = 1, respawn at 35.
REQ-038 Three misses -> blockgoneflag = 1 and stays high; gamestate = 01 -> blockgoneflag = 0, missCount = 0.
REQ-039 speedshift = 200000 -> period 50000; speedshift = 50'd300000 -> period saturates at 50000.
REQ-040 gamestate = 11 mid-fall -> blockY constant for 1e6 clocks, btn ignored; resetbtn asserted mid-fall -> all outputs 0 on the same edge.
